// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port: PS/2 keyboard receiver with glitch filter, frame checking,
// receive FIFO and a two-register CPU interface (DATA / STATUS).
module ps2_kbd_port #(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       sel,
   input  logic       reg_addr,
   input  logic       rd_strobe,
   input  logic       wr_strobe,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state_q, state_d;
   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          clk_f_q, clk_f_d;
   logic [FW-1:0] filt_q, filt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic          flip, fall, timeout, push, perr_set, ferr_set;
   logic          ne, full, pop, wr_en, clr;
   logic [4:0]    cnt5;
   logic [3:0]    stat_cnt;
   logic          unused;

   assign unused = ^{data_in[7:4], data_in[0]};

   always_comb begin
      clk_s1_d = ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_data;
      dat_s2_d = dat_s1_q;
      // A new level is accepted only after FILTER_LEN consecutive differing samples
      flip     = (clk_s2_q != clk_f_q) && (filt_q == FW'(FILTER_LEN - 1));
      filt_d   = (clk_s2_q == clk_f_q || flip) ? '0 : filt_q + 1'b1;
      clk_f_d  = flip ? clk_s2_q : clk_f_q;
      fall     = flip & clk_f_q;
      state_d  = state_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      par_d    = par_q;
      push     = 1'b0;
      perr_set = 1'b0;
      ferr_set = 1'b0;
      timeout  = (state_q != IDLE) && !fall && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
      if (timeout) begin
         state_d  = IDLE;
         ferr_set = 1'b1;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               state_d = dat_s2_q ? IDLE : DATA;
               bit_d   = 3'd0;
            end
            DATA: begin
               sh_d    = {dat_s2_q, sh_q[7:1]};
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            default: begin
               state_d  = IDLE;
               ferr_set = ~dat_s2_q;
               push     = dat_s2_q & (^{sh_q, par_q});
               perr_set = dat_s2_q & ~(^{sh_q, par_q});
            end
         endcase
      end
      tmr_d    = (state_d == IDLE || fall) ? '0 : tmr_q + 1'b1;
      ne       = cnt_q != '0;
      full     = cnt_q == CW'(FIFO_DEPTH);
      pop      = sel & rd_strobe & ~reg_addr & ne;
      wr_en    = push & (~full | pop);
      clr      = sel & wr_strobe & reg_addr;
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
      ovr_d    = (push & full & ~pop) | (ovr_q & ~(clr & data_in[1]));
      perr_d   = perr_set | (perr_q & ~(clr & data_in[2]));
      ferr_d   = ferr_set | (ferr_q & ~(clr & data_in[3]));
      cnt5     = 5'(cnt_q);
      stat_cnt = cnt5[4] ? 4'hF : cnt5[3:0];
      data_out = reg_addr ? {stat_cnt, ferr_q, perr_q, ovr_q, ne} : (ne ? mem_q[rd_ptr_q] : 8'h00);
      irq      = ne;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         clk_f_q  <= 1'b0;
         filt_q   <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         par_q    <= 1'b0;
         tmr_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovr_q    <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         clk_s1_q <= clk_s1_d;
         clk_s2_q <= clk_s2_d;
         dat_s1_q <= dat_s1_d;
         dat_s2_q <= dat_s2_d;
         clk_f_q  <= clk_f_d;
         filt_q   <= filt_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         par_q    <= par_d;
         tmr_q    <= tmr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovr_q    <= ovr_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= sh_q;
   end
endmodule
